// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction and data SRAM-like ports onto one AXI master.
// At most one transaction is outstanding per CPU port; responses route by ID.
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [DATA_W/8-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,

  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,

  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,

  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,

  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,

  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,

  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_WAITB
  } w_state_e;

  ar_state_e           ar_state_q, ar_state_d;
  logic [ADDR_W-1:0]   ar_addr_q,  ar_addr_d;
  logic [1:0]          ar_size_q,  ar_size_d;
  logic                ar_id_q,    ar_id_d;

  w_state_e            w_state_q,  w_state_d;
  logic [ADDR_W-1:0]   aw_addr_q,  aw_addr_d;
  logic [1:0]          aw_size_q,  aw_size_d;
  logic [STRB_W-1:0]   w_strb_q,   w_strb_d;
  logic [DATA_W-1:0]   w_data_q,   w_data_d;
  logic                aw_pend_q,  aw_pend_d;
  logic                w_pend_q,   w_pend_d;

  logic                inst_busy_q, inst_busy_d;
  logic                data_busy_q, data_busy_d;

  logic                data_rd_cand, data_wr_cand, inst_rd_cand;
  logic                inst_grant, data_rd_grant, data_wr_grant;
  logic                r_inst, r_data, b_data;

  // Qualifying with resetn keeps every handshake output low while reset is held.
  assign data_rd_cand = resetn & data_sram_req & ~data_sram_wr & ~data_busy_q;
  assign data_wr_cand = resetn & data_sram_req &  data_sram_wr & ~data_busy_q;
  assign inst_rd_cand = resetn & inst_sram_req & ~inst_busy_q;

  assign r_inst = resetn & rvalid & (rid == 4'd0);
  assign r_data = resetn & rvalid & (rid == 4'd1);
  assign b_data = resetn & bvalid;

  always_comb begin
    ar_state_d    = ar_state_q;
    ar_addr_d     = ar_addr_q;
    ar_size_d     = ar_size_q;
    ar_id_d       = ar_id_q;
    inst_grant    = 1'b0;
    data_rd_grant = 1'b0;
    unique case (ar_state_q)
      AR_IDLE: begin
        if (data_rd_cand) begin
          data_rd_grant = 1'b1;
          ar_addr_d     = data_sram_addr;
          ar_size_d     = data_sram_size;
          ar_id_d       = 1'b1;
          ar_state_d    = AR_SEND;
        end else if (inst_rd_cand) begin
          inst_grant = 1'b1;
          ar_addr_d  = inst_sram_addr;
          ar_size_d  = inst_sram_size;
          ar_id_d    = 1'b0;
          ar_state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        if (arready) ar_state_d = AR_IDLE;
      end
    endcase
  end

  always_comb begin
    w_state_d     = w_state_q;
    aw_addr_d     = aw_addr_q;
    aw_size_d     = aw_size_q;
    w_strb_d      = w_strb_q;
    w_data_d      = w_data_q;
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    data_wr_grant = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (data_wr_cand) begin
          data_wr_grant = 1'b1;
          aw_addr_d     = data_sram_addr;
          aw_size_d     = data_sram_size;
          w_strb_d      = data_sram_wstrb;
          w_data_d      = data_sram_wdata;
          aw_pend_d     = 1'b1;
          w_pend_d      = 1'b1;
          w_state_d     = W_SEND;
        end
      end
      W_SEND: begin
        // AW and W complete independently, in either order or together.
        if (awready) aw_pend_d = 1'b0;
        if (wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) w_state_d = W_WAITB;
      end
      W_WAITB: begin
        if (bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign inst_busy_d = (inst_busy_q & ~r_inst) | inst_grant;
  assign data_busy_d = (data_busy_q & ~(r_data | b_data)) | data_rd_grant | data_wr_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q  <= AR_IDLE;
      ar_addr_q   <= '0;
      ar_size_q   <= '0;
      ar_id_q     <= 1'b0;
      w_state_q   <= W_IDLE;
      aw_addr_q   <= '0;
      aw_size_q   <= '0;
      w_strb_q    <= '0;
      w_data_q    <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
    end else begin
      ar_state_q  <= ar_state_d;
      ar_addr_q   <= ar_addr_d;
      ar_size_q   <= ar_size_d;
      ar_id_q     <= ar_id_d;
      w_state_q   <= w_state_d;
      aw_addr_q   <= aw_addr_d;
      aw_size_q   <= aw_size_d;
      w_strb_q    <= w_strb_d;
      w_data_q    <= w_data_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      inst_busy_q <= inst_busy_d;
      data_busy_q <= data_busy_d;
    end
  end

  assign inst_sram_addr_ok = inst_grant;
  assign data_sram_addr_ok = data_rd_grant | data_wr_grant;
  assign inst_sram_data_ok = r_inst;
  assign data_sram_data_ok = r_data | b_data;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arvalid = (ar_state_q == AR_SEND);
  assign arid    = {3'b000, ar_id_q};
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign rready  = resetn;

  assign awvalid = (w_state_q == W_SEND) & aw_pend_q;
  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, aw_size_q};
  assign wvalid  = (w_state_q == W_SEND) & w_pend_q;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign bready  = resetn;

  logic unused_inst_write;
  assign unused_inst_write = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios followed by a randomized run against a queue-based
// model of the bridge's grant and routing rules.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic inst_req(input logic [31:0] a, input logic [1:0] s);
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
    inst_sram_size = s;
  endtask

  task automatic data_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic [3:0] st, input logic [31:0] d);
    data_sram_req   = 1'b1;
    data_sram_wr    = w;
    data_sram_addr  = a;
    data_sram_size  = s;
    data_sram_wstrb = st;
    data_sram_wdata = d;
  endtask

  // Called in a cycle where a read address is expected on AR; completes it.
  task automatic ar_expect(input logic [3:0] id, input logic [31:0] a, input logic [2:0] s);
    arready = 1'b1;
    #1;
    check("ar_valid", arvalid, 1'b1);
    check("ar_id", arid, id);
    check("ar_addr", araddr, a);
    check("ar_size", arsize, s);
    tick;
    arready = 1'b0;
  endtask

  task automatic r_return(input logic [3:0] id, input logic [31:0] d, input logic exp_iaok);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    #1;
    check("r_inst_data_ok", inst_sram_data_ok, id == 4'd0);
    check("r_data_data_ok", data_sram_data_ok, id == 4'd1);
    check("r_inst_rdata", inst_sram_rdata, d);
    check("r_data_rdata", data_sram_rdata, d);
    check("r_inst_addr_ok", inst_sram_addr_ok, exp_iaok);
    tick;
    rvalid = 1'b0;
  endtask

  task automatic b_return;
    bvalid = 1'b1;
    #1;
    check("b_data_ok", data_sram_data_ok, 1'b1);
    check("b_inst_data_ok", inst_sram_data_ok, 1'b0);
    tick;
    bvalid = 1'b0;
  endtask

  // Model state for the randomized run.
  logic  ibusy, dbusy, wr_active, aw_pend, w_pend, b_due;
  logic  r_fire, b_fire, acc_i, acc_d_rd, acc_d_wr, d_cand;
  ar_t   arq[$];
  logic [3:0] rspq[$];
  ar_t   ent;
  logic [31:0] ew_addr, ew_data;
  logic [2:0]  ew_size;
  logic [3:0]  ew_strb;

  initial begin
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    tick;
    tick;

    // Reset state, with requests asserted that must not be acknowledged.
    inst_sram_req = 1; data_sram_req = 1; data_sram_wr = 1;
    settle;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_iaok", inst_sram_addr_ok, 1'b0);
    check("rst_daok", data_sram_addr_ok, 1'b0);
    inst_sram_req = 0; data_sram_req = 0; data_sram_wr = 0;
    resetn = 1'b1;
    tick;
    check("post_rst_rready", rready, 1'b1);
    check("post_rst_bready", bready, 1'b1);

    // 1: instruction fetch.
    inst_req(32'h1c000000, 2'd2);
    settle;
    check("t1_iaok", inst_sram_addr_ok, 1'b1);
    check("t1_daok", data_sram_addr_ok, 1'b0);
    check("t1_arvalid_c0", arvalid, 1'b0);
    tick;
    inst_sram_req = 0;
    settle;
    check("t1_arvalid_c1", arvalid, 1'b1);
    check("t1_araddr_c1", araddr, 32'h1c000000);
    check("t1_arid_c1", arid, 4'd0);
    check("t1_arsize_c1", arsize, 3'd2);
    tick;
    settle;
    check("t1_arvalid_c2", arvalid, 1'b1);
    tick;
    ar_expect(4'd0, 32'h1c000000, 3'd2);
    settle;
    check("t1_arvalid_c4", arvalid, 1'b0);
    tick;
    tick;
    r_return(4'd0, 32'h02800c0c, 1'b0);

    // 2: simultaneous reads, data wins; second inst req waits for rid 0.
    inst_req(32'h1c000004, 2'd2);
    data_req(1'b0, 32'h800d0010, 2'd2, 4'h0, 32'h0);
    settle;
    check("t2_daok", data_sram_addr_ok, 1'b1);
    check("t2_iaok_lose", inst_sram_addr_ok, 1'b0);
    tick;
    data_sram_req = 0;
    settle;
    check("t2_iaok_send", inst_sram_addr_ok, 1'b0);
    ar_expect(4'd1, 32'h800d0010, 3'd2);
    settle;
    check("t2_iaok_idle", inst_sram_addr_ok, 1'b1);
    check("t2_arvalid_idle", arvalid, 1'b0);
    tick;
    inst_sram_req = 0;
    ar_expect(4'd0, 32'h1c000004, 3'd2);
    inst_req(32'h1c000008, 2'd2);
    settle;
    check("t2_iaok_busy", inst_sram_addr_ok, 1'b0);
    r_return(4'd1, 32'h11112222, 1'b0);
    settle;
    check("t2_iaok_busy2", inst_sram_addr_ok, 1'b0);
    r_return(4'd0, 32'h33334444, 1'b0);
    settle;
    check("t2_iaok_free", inst_sram_addr_ok, 1'b1);
    tick;
    inst_sram_req = 0;
    ar_expect(4'd0, 32'h1c000008, 3'd2);
    r_return(4'd0, 32'h55556666, 1'b0);

    // 3 + 4: write with W before AW, then a read to the same address.
    data_req(1'b1, 32'h800d0000, 2'd2, 4'hf, 32'hdeadbeef);
    settle;
    check("t3_daok", data_sram_addr_ok, 1'b1);
    tick;
    data_sram_req = 0;
    wready = 1;
    settle;
    check("t3_awvalid_c1", awvalid, 1'b1);
    check("t3_wvalid_c1", wvalid, 1'b1);
    check("t3_awaddr", awaddr, 32'h800d0000);
    check("t3_awsize", awsize, 3'd2);
    check("t3_wdata", wdata, 32'hdeadbeef);
    check("t3_wstrb", wstrb, 4'hf);
    tick;
    wready = 0;
    data_req(1'b0, 32'h800d0000, 2'd2, 4'h0, 32'h0);
    settle;
    check("t3_wvalid_c2", wvalid, 1'b0);
    check("t3_awvalid_c2", awvalid, 1'b1);
    check("t4_daok_c2", data_sram_addr_ok, 1'b0);
    tick;
    awready = 1;
    settle;
    check("t3_awvalid_c3", awvalid, 1'b1);
    check("t4_daok_c3", data_sram_addr_ok, 1'b0);
    tick;
    awready = 0;
    settle;
    check("t3_awvalid_c4", awvalid, 1'b0);
    check("t3_wvalid_c4", wvalid, 1'b0);
    check("t4_daok_c4", data_sram_addr_ok, 1'b0);
    check("t4_arvalid_c4", arvalid, 1'b0);
    tick;
    bvalid = 1;
    settle;
    check("t3_b_data_ok", data_sram_data_ok, 1'b1);
    check("t4_daok_b", data_sram_addr_ok, 1'b0);
    tick;
    bvalid = 0;
    settle;
    check("t4_daok_after_b", data_sram_addr_ok, 1'b1);
    check("t3_no_extra_data_ok", data_sram_data_ok, 1'b0);
    check("t4_arvalid_accept", arvalid, 1'b0);
    tick;
    data_sram_req = 0;
    ar_expect(4'd1, 32'h800d0000, 3'd2);
    r_return(4'd1, 32'hdeadbeef, 1'b0);

    // 5: byte write alongside an instruction read, AW and W in the same cycle.
    data_req(1'b1, 32'h800d0003, 2'd0, 4'h8, 32'haa000000);
    inst_req(32'h1c00000c, 2'd2);
    settle;
    check("t5_daok", data_sram_addr_ok, 1'b1);
    check("t5_iaok", inst_sram_addr_ok, 1'b1);
    tick;
    data_sram_req = 0;
    inst_sram_req = 0;
    awready = 1;
    wready = 1;
    settle;
    check("t5_awvalid", awvalid, 1'b1);
    check("t5_wvalid", wvalid, 1'b1);
    check("t5_awsize", awsize, 3'd0);
    check("t5_awaddr", awaddr, 32'h800d0003);
    check("t5_wstrb", wstrb, 4'h8);
    check("t5_wdata", wdata, 32'haa000000);
    check("t5_arvalid", arvalid, 1'b1);
    check("t5_arid", arid, 4'd0);
    tick;
    awready = 0;
    wready = 0;
    settle;
    check("t5_awvalid_done", awvalid, 1'b0);
    check("t5_wvalid_done", wvalid, 1'b0);
    ar_expect(4'd0, 32'h1c00000c, 3'd2);
    b_return;
    r_return(4'd0, 32'h77778888, 1'b0);

    // 6: asynchronous reset while an address is on AR.
    inst_req(32'h1c000010, 2'd2);
    settle;
    check("t6_iaok", inst_sram_addr_ok, 1'b1);
    tick;
    settle;
    check("t6_arvalid_pre", arvalid, 1'b1);
    resetn = 1'b0;
    #1;
    check("t6_arvalid_rst", arvalid, 1'b0);
    check("t6_rready_rst", rready, 1'b0);
    check("t6_iaok_rst", inst_sram_addr_ok, 1'b0);
    resetn = 1'b1;
    #1;
    check("t6_iaok_release", inst_sram_addr_ok, 1'b1);
    check("t6_arvalid_release", arvalid, 1'b0);
    check("t6_rready_release", rready, 1'b1);
    tick;
    inst_sram_req = 0;
    ar_expect(4'd0, 32'h1c000010, 3'd2);
    r_return(4'd0, 32'h9999aaaa, 1'b0);

    // Randomized traffic against the queue model.
    ibusy = 0; dbusy = 0; wr_active = 0; aw_pend = 0; w_pend = 0; b_due = 0;
    ew_addr = 0; ew_data = 0; ew_size = 0; ew_strb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!inst_sram_req && $urandom_range(0, 2) == 0) begin
        inst_sram_req  = 1'b1;
        inst_sram_addr = $urandom;
        inst_sram_size = 2'($urandom_range(0, 3));
      end
      inst_sram_wr    = 1'($urandom_range(0, 1));
      inst_sram_wstrb = 4'($urandom);
      inst_sram_wdata = $urandom;
      if (!data_sram_req && $urandom_range(0, 2) == 0) begin
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'($urandom_range(0, 1));
        data_sram_addr  = $urandom;
        data_sram_size  = 2'($urandom_range(0, 3));
        data_sram_wstrb = 4'($urandom);
        data_sram_wdata = $urandom;
      end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      r_fire  = (rspq.size() != 0) && ($urandom_range(0, 1) == 1);
      rvalid  = r_fire;
      rid     = r_fire ? rspq[0] : 4'($urandom_range(2, 15));
      rdata   = $urandom;
      b_fire  = b_due && ($urandom_range(0, 1) == 1);
      bvalid  = b_fire;
      #1;

      d_cand   = data_sram_req & ~data_sram_wr & ~dbusy;
      acc_d_rd = d_cand & (arq.size() == 0);
      acc_d_wr = data_sram_req & data_sram_wr & ~dbusy & ~wr_active;
      acc_i    = inst_sram_req & ~ibusy & (arq.size() == 0) & ~d_cand;
      check("rnd_daok", data_sram_addr_ok, acc_d_rd | acc_d_wr);
      check("rnd_iaok", inst_sram_addr_ok, acc_i);
      check("rnd_inst_data_ok", inst_sram_data_ok, r_fire && (rid == 4'd0));
      check("rnd_data_data_ok", data_sram_data_ok, (r_fire && (rid == 4'd1)) || b_fire);
      if (r_fire) begin
        check("rnd_inst_rdata", inst_sram_rdata, rdata);
        check("rnd_data_rdata", data_sram_rdata, rdata);
      end
      check("rnd_arvalid", arvalid, arq.size() != 0);
      if (arq.size() != 0) begin
        check("rnd_arid", arid, arq[0].id);
        check("rnd_araddr", araddr, arq[0].addr);
        check("rnd_arsize", arsize, arq[0].size);
      end
      check("rnd_awvalid", awvalid, aw_pend);
      check("rnd_wvalid", wvalid, w_pend);
      if (aw_pend) begin
        check("rnd_awaddr", awaddr, ew_addr);
        check("rnd_awsize", awsize, ew_size);
      end
      if (w_pend) begin
        check("rnd_wdata", wdata, ew_data);
        check("rnd_wstrb", wstrb, ew_strb);
      end
      check("rnd_rready", rready, 1'b1);
      check("rnd_bready", bready, 1'b1);

      if (r_fire) begin
        if (rspq[0] == 4'd0) ibusy = 0;
        else dbusy = 0;
        void'(rspq.pop_front());
      end
      if (b_fire) begin
        b_due = 0;
        wr_active = 0;
        dbusy = 0;
      end
      if ((arq.size() != 0) && arready) begin
        rspq.push_back(arq[0].id);
        void'(arq.pop_front());
      end
      if (aw_pend && awready) aw_pend = 0;
      if (w_pend && wready) w_pend = 0;
      if (wr_active && !aw_pend && !w_pend && !b_fire) b_due = 1;
      if (acc_d_rd) begin
        ent.id = 4'd1; ent.addr = data_sram_addr; ent.size = {1'b0, data_sram_size};
        arq.push_back(ent);
        dbusy = 1;
      end
      if (acc_i) begin
        ent.id = 4'd0; ent.addr = inst_sram_addr; ent.size = {1'b0, inst_sram_size};
        arq.push_back(ent);
        ibusy = 1;
      end
      if (acc_d_wr) begin
        wr_active = 1; aw_pend = 1; w_pend = 1; dbusy = 1;
        ew_addr = data_sram_addr; ew_size = {1'b0, data_sram_size};
        ew_data = data_sram_wdata; ew_strb = data_sram_wstrb;
      end

      tick;
      if (acc_i) inst_sram_req = 1'b0;
      if (acc_d_rd || acc_d_wr) data_sram_req = 1'b0;
    end

    rvalid = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
    inst_sram_req = 0; data_sram_req = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
